// File: rtl/one_by_n_gen.sv
// Sequential reciprocal: one_by_n = floor(2^FRAC_W / n) in unsigned Q1.FRAC_W, one bit per clock.
// Define ONE_BY_N_ROUND_EN for a guard iteration and round-half-up (latency OUT_W+1).
module one_by_n_gen #(
  parameter int unsigned N_W    = 16,
  parameter int unsigned FRAC_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_W-1:0]    n,
  output logic              busy,
  output logic              done,
  output logic [FRAC_W:0]   one_by_n,
  output logic              div_zero
);

  localparam int unsigned OUT_W = FRAC_W + 1;
`ifdef ONE_BY_N_ROUND_EN
  localparam int unsigned Q_W = OUT_W + 1;
`else
  localparam int unsigned Q_W = OUT_W;
`endif
  localparam int unsigned CNT_W = $clog2(Q_W);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e             state_q, state_d;
  logic [N_W-1:0]     n_q, n_d;
  logic [N_W:0]       rem_q, rem_d;
  logic [Q_W-1:0]     quo_q, quo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [OUT_W-1:0]   res_q, res_d;
  logic               dz_q, dz_d;

  logic               div_bit;
  logic               ge;
  logic [N_W:0]       rem_sh;
  logic [N_W:0]       diff;
  logic [Q_W-1:0]     quo_nx;
  logic [OUT_W-1:0]   result;

  always_comb begin
    // Dividend is a single 1 followed by zeros, so only the first shift brings in a 1.
    div_bit = (cnt_q == '0);
    rem_sh  = (rem_q << 1) | {{N_W{1'b0}}, div_bit};
    diff    = rem_sh - {1'b0, n_q};
    ge      = (rem_sh >= {1'b0, n_q});
    quo_nx  = (quo_q << 1) | {{(Q_W-1){1'b0}}, ge};
`ifdef ONE_BY_N_ROUND_EN
    // quo_nx = floor(2^(FRAC_W+1)/n); adding the guard bit and halving rounds half up.
    result  = OUT_W'((quo_nx + Q_W'(1)) >> 1);
`else
    result  = quo_nx;
`endif
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    res_d   = res_q;
    dz_d    = dz_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          busy_d = 1'b1;
          if (n == '0) begin
            state_d = StDone;
            done_d  = 1'b1;
            res_d   = '1;
            dz_d    = 1'b1;
          end else begin
            state_d = StCalc;
            n_d     = n;
            rem_d   = '0;
            quo_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      StCalc: begin
        rem_d = ge ? diff : rem_sh;
        quo_d = quo_nx;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(Q_W - 1)) begin
          state_d = StDone;
          done_d  = 1'b1;
          res_d   = result;
          dz_d    = 1'b0;
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      n_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_q   <= res_d;
      dz_q    <= dz_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign one_by_n = res_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_one_by_n_gen.sv
// Bench for one_by_n_gen: vector table plus reset/restart sequences, results checked via a queue.
module tb_one_by_n_gen;

`ifdef ONE_BY_N_ROUND_EN
  localparam int Lat = 18;
`else
  localparam int Lat = 17;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] n = '0;
  logic        busy, done, div_zero;
  logic [16:0] one_by_n;

  one_by_n_gen dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .n        (n),
    .busy     (busy),
    .done     (done),
    .one_by_n (one_by_n),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    logic [16:0] val;
    logic        dz;
    int          due;
  } exp_t;

  typedef struct {
    logic [15:0] nv;
    logic [16:0] q_trunc;
    logic [16:0] q_round;
    logic        dz;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_done", {31'd0, done}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("one_by_n", {15'd0, one_by_n}, {15'd0, e.val});
        check("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
        check("latency", cyc, e.due);
        check("busy_with_done", {31'd0, busy}, 32'd1);
      end
    end
  end

  task automatic issue(input logic [15:0] nv, input logic [16:0] ev, input logic dz);
    exp_t e;
    @(negedge clk); #1;
    start = 1'b1;
    n     = nv;
    e.val = ev;
    e.dz  = dz;
    e.due = cyc + 1 + ((nv == 16'd0) ? 0 : Lat);
    sb.push_back(e);
    @(negedge clk); #1;
    start = 1'b0;
    n     = 16'($urandom);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 60 && sb.size() != 0; k++) begin
      @(negedge clk); #1;
    end
    if (sb.size() != 0) begin
      check({name, "_timeout"}, sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  task automatic after_done(input string name, input logic [16:0] ev);
    @(negedge clk); #1;
    check({name, "_busy_after"}, {31'd0, busy}, 32'd0);
    check({name, "_done_after"}, {31'd0, done}, 32'd0);
    check({name, "_hold"}, {15'd0, one_by_n}, {15'd0, ev});
  endtask

  task automatic check_zero(input string name);
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
    check({name, "_done"}, {31'd0, done}, 32'd0);
    check({name, "_one_by_n"}, {15'd0, one_by_n}, 32'd0);
    check({name, "_div_zero"}, {31'd0, div_zero}, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [16:0] ev;

    vecs[0]  = '{16'd2,     17'd32768,   17'd32768,   1'b0};
    vecs[1]  = '{16'd1,     17'd65536,   17'd65536,   1'b0};
    vecs[2]  = '{16'd3,     17'd21845,   17'd21845,   1'b0};
    vecs[3]  = '{16'd6,     17'd10922,   17'd10923,   1'b0};
    vecs[4]  = '{16'd65535, 17'd1,       17'd1,       1'b0};
    vecs[5]  = '{16'd0,     17'h1FFFF,   17'h1FFFF,   1'b1};
    vecs[6]  = '{16'd7,     17'd9362,    17'd9362,    1'b0};
    vecs[7]  = '{16'd1000,  17'd65,      17'd66,      1'b0};
    vecs[8]  = '{16'd40000, 17'd1,       17'd2,       1'b0};
    vecs[9]  = '{16'd32768, 17'd2,       17'd2,       1'b0};
    vecs[10] = '{16'd5,     17'd13107,   17'd13107,   1'b0};
    vecs[11] = '{16'd65534, 17'd1,       17'd1,       1'b0};

    // Reset state, then a reset pulse in idle with start held.
    repeat (2) @(negedge clk);
    check_zero("reset");
    #1 rst = 1'b0;
    @(negedge clk); #1;
    start = 1'b1;
    n     = 16'd5;
    #2 rst = 1'b1;
    @(negedge clk);
    check_zero("reset_start_held");
    #1 start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_zero("idle_after_reset");

    for (int i = 0; i < 12; i++) begin
`ifdef ONE_BY_N_ROUND_EN
      ev = vecs[i].q_round;
`else
      ev = vecs[i].q_trunc;
`endif
      issue(vecs[i].nv, ev, vecs[i].dz);
      drain($sformatf("vec%0d", i));
      after_done($sformatf("vec%0d", i), ev);
    end

    // Second start while busy must be ignored.
    issue(16'd4, 17'd16384, 1'b0);
    repeat (3) begin
      @(negedge clk); #1;
    end
    check("restart_busy", {31'd0, busy}, 32'd1);
    start = 1'b1;
    n     = 16'd5;
    @(negedge clk); #1;
    start = 1'b0;
    drain("restart");
    after_done("restart", 17'd16384);
    repeat (25) @(negedge clk);

    // Reset mid-calculation aborts without a done pulse.
    issue(16'd7, 17'd9362, 1'b0);
    repeat (7) begin
      @(negedge clk); #1;
    end
    rst = 1'b1;
    sb.delete();
    #1;
    check_zero("abort");
    @(negedge clk); #1;
    rst = 1'b0;
    repeat (25) @(negedge clk);
    #1;
    check_zero("abort_quiet");
    issue(16'd7, 17'd9362, 1'b0);
    drain("after_abort");
    after_done("after_abort", 17'd9362);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
